// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the core's fetch (I) and load/store (D) ports
// and the shared-memory arbiter.
interface mem_port_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             i_req;
   logic [31:0]      i_addr;
   logic             i_ack;
   logic             i_err;
   logic             d_req;
   logic [31:0]      d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic             d_we;
   logic             d_ack;
   logic             d_err;
   logic [WIDTH-1:0] rdata;

   modport master (
      output i_req, i_addr, d_req, d_addr, d_wdata, d_we,
      input  i_ack, i_err, d_ack, d_err, rdata
   );

   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_wdata, d_we,
      output i_ack, i_err, d_ack, d_err, rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the fetch and
// load/store ports; one access in flight, IDLE -> ACCESS -> RESP per access.
module mem_port_arbiter #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   mem_port_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [WIDTH-1:0]  o_mem_wdi,
   output logic              o_mem_we,
   input  logic [WIDTH-1:0]  i_mem_do,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_grant_d;
   logic              r_last_d;
   logic              r_mis;
   logic              r_we;
   logic [ADDR_W-1:0] r_idx;
   logic [WIDTH-1:0]  r_wdata;
   logic [WIDTH-1:0]  r_rdata;
   logic              w_start;
   logic              w_pick_d;
   logic [31:0]       w_addr_sel;
   logic              w_unused_addr;

   assign w_addr_sel    = w_pick_d ? bus.d_addr : bus.i_addr;
   // High address bits are dropped on purpose: addresses wrap by truncation.
   assign w_unused_addr = ^w_addr_sel[31:ADDR_W+2];

   // Next-state and arbitration decode; only IDLE samples the requests.
   always_comb begin
      w_next   = r_state;
      w_start  = 1'b0;
      w_pick_d = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_req && bus.d_req) begin
               w_start  = 1'b1;
               w_pick_d = ~r_last_d;
            end else if (bus.i_req) begin
               w_start  = 1'b1;
               w_pick_d = 1'b0;
            end else if (bus.d_req) begin
               w_start  = 1'b1;
               w_pick_d = 1'b1;
            end else begin
               w_start  = 1'b0;
               w_pick_d = 1'b0;
            end
            if (w_start) begin
               w_next = ST_ACCESS;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_ACCESS: w_next = ST_RESP;
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Latch the granted request in IDLE; capture read data and fairness pointer at end of ACCESS.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grant_d <= 1'b0;
         r_last_d  <= 1'b1;
         r_mis     <= 1'b0;
         r_we      <= 1'b0;
         r_idx     <= {ADDR_W{1'b0}};
         r_wdata   <= {WIDTH{1'b0}};
         r_rdata   <= {WIDTH{1'b0}};
      end else begin
         if (w_start) begin
            r_grant_d <= w_pick_d;
            r_idx     <= w_addr_sel[ADDR_W+1:2];
            r_mis     <= (w_addr_sel[1:0] != 2'b00);
            r_we      <= w_pick_d & bus.d_we;
            r_wdata   <= w_pick_d ? bus.d_wdata : {WIDTH{1'b0}};
         end
         if (r_state == ST_ACCESS) begin
            r_rdata  <= i_mem_do;
            r_last_d <= r_grant_d;
         end
      end
   end

   assign o_mem_addr = r_idx;
   assign o_mem_wdi  = r_wdata;
   // A misaligned store never reaches the memory write enable.
   assign o_mem_we   = (r_state == ST_ACCESS) & r_we & ~r_mis;
   assign o_busy     = (r_state != ST_IDLE);

   assign bus.i_ack  = (r_state == ST_RESP) & ~r_grant_d;
   assign bus.d_ack  = (r_state == ST_RESP) &  r_grant_d;
   assign bus.i_err  = bus.i_ack & r_mis;
   assign bus.d_err  = bus.d_ack & r_mis;
   assign bus.rdata  = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdi;
   logic              mem_we;
   logic [WIDTH-1:0]  mem_do;
   logic              busy;
   logic [WIDTH-1:0]  mem [0:(1<<ADDR_W)-1];

   int n_cmp;
   int n_bad;

   mem_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

   mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .bus        (bus.slave),
      .o_mem_addr (mem_addr),
      .o_mem_wdi  (mem_wdi),
      .o_mem_we   (mem_we),
      .i_mem_do   (mem_do),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdi;
   end
   assign mem_do = mem[mem_addr];

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete access: request at a negedge, ACCESS one cycle later, ACK two cycles later.
   task automatic run_access(input logic is_d, input logic [31:0] addr, input logic we,
                             input logic [31:0] wd, input logic [4:0] exp_ma,
                             input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
      @(negedge clk);
      if (is_d) begin
         bus.d_req = 1'b1; bus.d_addr = addr; bus.d_we = we; bus.d_wdata = wd;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = addr;
      end
      @(negedge clk);
      chk_eq("busy_access", {31'd0, busy}, 32'd1);
      chk_eq("ack_access", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
      chk_eq("mem_addr", {27'd0, mem_addr}, {27'd0, exp_ma});
      chk_eq("mem_we_access", {31'd0, mem_we}, {31'd0, is_d & we & ~exp_err});
      chk_eq("mem_wdi", mem_wdi, is_d ? wd : 32'd0);
      @(negedge clk);
      chk_eq("ack_resp", {30'd0, bus.i_ack, bus.d_ack}, is_d ? 32'd1 : 32'd2);
      chk_eq("err_resp", {30'd0, bus.i_err, bus.d_err},
             is_d ? {31'd0, exp_err} : {30'd0, exp_err, 1'b0});
      chk_eq("mem_we_resp", {31'd0, mem_we}, 32'd0);
      if (chk_rd) chk_eq("rdata", bus.rdata, exp_rd);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);
      chk_eq("ack_after", {28'd0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 32'd0);
      chk_eq("busy_after", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.i_req = 1'b0; bus.i_addr = 32'd0;
      bus.d_req = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0; bus.d_we = 1'b0;
      for (int k = 0; k < (1 << ADDR_W); k++) mem[k] <= 32'h0000_0000;
      mem[1] <= 32'hA5A5_0001;
      mem[2] <= 32'hE3A0_0001;
      mem[4] <= 32'h1111_1111;

      repeat (2) @(negedge clk);
      chk_eq("reset_outs", {25'd0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, mem_we, busy, 1'b0}, 32'd0);
      chk_eq("reset_rdata", bus.rdata, 32'd0);
      chk_eq("reset_maddr", {27'd0, mem_addr}, 32'd0);
      chk_eq("reset_mwdi", mem_wdi, 32'd0);
      rst_n = 1'b1;

      // Fetch, store, load-back, misaligned store, truncated address, misaligned fetch.
      run_access(1'b0, 32'h0000_0008, 1'b0, 32'd0, 5'd2, 1'b0, 1'b1, 32'hE3A0_0001);
      run_access(1'b1, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 5'd4, 1'b0, 1'b1, 32'h1111_1111);
      chk_eq("mem4_stored", mem[4], 32'hDEAD_BEEF);
      run_access(1'b1, 32'h0000_0010, 1'b0, 32'd0, 5'd4, 1'b0, 1'b1, 32'hDEAD_BEEF);
      run_access(1'b1, 32'h0000_0013, 1'b1, 32'h1234_5678, 5'd4, 1'b1, 1'b0, 32'd0);
      chk_eq("mem4_unchanged", mem[4], 32'hDEAD_BEEF);
      run_access(1'b1, 32'h0000_0084, 1'b0, 32'd0, 5'd1, 1'b0, 1'b1, 32'hA5A5_0001);
      run_access(1'b0, 32'h0000_000A, 1'b0, 32'd0, 5'd2, 1'b1, 1'b0, 32'd0);

      // REQ dropped right after being sampled: access still completes.
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_0004;
      @(negedge clk);
      bus.i_req = 1'b0;
      @(negedge clk);
      chk_eq("dropped_req_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd2);
      chk_eq("dropped_req_rdata", bus.rdata, 32'hA5A5_0001);
      @(negedge clk);

      // Contention from reset: I wins first, then strict alternation every 3 cycles.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_0008;
      bus.d_req = 1'b1; bus.d_addr = 32'h0000_0004; bus.d_we = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         chk_eq($sformatf("rr_ack_c%0d", j), {30'd0, bus.i_ack, bus.d_ack},
                (j == 2 || j == 8) ? 32'd2 : ((j == 5 || j == 11) ? 32'd1 : 32'd0));
         if (j == 2 || j == 8)  chk_eq($sformatf("rr_rdata_c%0d", j), bus.rdata, 32'hE3A0_0001);
         if (j == 5 || j == 11) chk_eq($sformatf("rr_rdata_c%0d", j), bus.rdata, 32'hA5A5_0001);
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      repeat (3) @(negedge clk);

      // Reset asserted in the middle of a D load's ACCESS cycle.
      bus.d_req = 1'b1; bus.d_addr = 32'h0000_0010; bus.d_we = 1'b0;
      @(negedge clk);
      chk_eq("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("mid_reset_outs", {26'd0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, mem_we, busy}, 32'd0);
      chk_eq("mid_reset_rdata", bus.rdata, 32'd0);
      chk_eq("mid_reset_maddr", {27'd0, mem_addr}, 32'd0);
      bus.d_req = 1'b0;
      @(negedge clk);
      chk_eq("reset_no_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
      rst_n = 1'b1;
      run_access(1'b0, 32'h0000_0008, 1'b0, 32'd0, 5'd2, 1'b0, 1'b1, 32'hE3A0_0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
